sid_audio_out: RTL

SID_AUDIO_OUT -- requirements
Module: sid_audio_out

---
 rtl/sid_pkg.sv | 25 ++
 rtl/sid_i2s_tx.sv | 77 +++++++
 rtl/sid_audio_out.sv | 68 ++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared SID types and constants used by the audio output path.
// Slot formatting and mono mixing helpers live here so every consumer agrees on them.
package sid;

    typedef logic [3:0]         cycle_t;
    typedef logic signed [19:0] s20_t;

    localparam int     I2S_SLOT_BITS   = 32;
    localparam int     I2S_SAMPLE_BITS = 24;
    localparam cycle_t AUDIO_CYCLE_0   = 4'd9;
    localparam cycle_t AUDIO_CYCLE_1   = 4'd14;

    // Left-justified 20-bit sample inside a 24-bit word, padded to a full slot.
    function automatic logic [I2S_SLOT_BITS-1:0] slot_word(input s20_t sample);
        return {sample, 4'b0000, {(I2S_SLOT_BITS - I2S_SAMPLE_BITS){1'b0}}};
    endfunction

    // A 21-bit signed sum halved always fits back into 20 bits.
    function automatic s20_t mono_mix(input s20_t a, input s20_t b);
        logic signed [20:0] sum;
        sum = {a[19], a} + {b[19], b};
        return sum[20:1];
    endfunction

endpackage

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter: SCK divider, 64-bit frame index, WS and MSB-first shift register.
// All outputs are registers; SD and WS move only when SCK falls.
module sid_i2s_tx #(
    parameter int SCK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] frame_word,
    output logic        i2s_sck,
    output logic        i2s_ws,
    output logic        i2s_sd,
    output logic        frame_o
);

    localparam int             CW      = $clog2(SCK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0]  HALF    = CW'(SCK_DIV / 2);

    if ((SCK_DIV % 2) != 0 || SCK_DIV < 4) begin : g_bad_sck_div
        $error("sid_i2s_tx: SCK_DIV must be even and at least 4");
    end

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [5:0]    b_r;
    logic [5:0]    b_nxt_s;
    logic          fall_s;
    logic          load_s;
    logic [63:0]   shift_r;
    logic          sck_r;
    logic          ws_r;
    logic          frame_r;

    // Next divider / bit-index values and the frame-load strobe.
    always_comb begin
        fall_s = (cnt_r == CNT_MAX);
        load_s = fall_s && (b_r == 6'd63);
        if (fall_s) begin
            cnt_nxt_s = '0;
            b_nxt_s   = b_r + 6'd1;
        end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            b_nxt_s   = b_r;
        end
    end

    // Divider, index, line registers and shift register; WS leads each slot MSB by one SCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            b_r     <= 6'd0;
            sck_r   <= 1'b0;
            ws_r    <= 1'b0;
            frame_r <= 1'b0;
            shift_r <= 64'd0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            b_r     <= b_nxt_s;
            sck_r   <= (cnt_nxt_s >= HALF);
            ws_r    <= (b_nxt_s >= 6'd31) && (b_nxt_s <= 6'd62);
            frame_r <= load_s;
            if (load_s) begin
                shift_r <= frame_word;
            end else if (fall_s) begin
                shift_r <= {shift_r[62:0], 1'b0};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    assign i2s_sck = sck_r;
    assign i2s_ws  = ws_r;
    assign i2s_sd  = shift_r[63];
    assign frame_o = frame_r;

endmodule

// File: rtl/sid_audio_out.sv
// Captures the two SID chip samples from the TDM audio bus and streams them out over I2S.
// A coherent left/right pair is latched on the chip-1 slot and sampled by the transmitter once per frame.
module sid_audio_out
    import sid::*;
#(
    parameter int SCK_DIV = 8,
    parameter int MONO    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  sid::cycle_t cycle,
    input  sid::s20_t   audio_i,
    output logic        i2s_sck,
    output logic        i2s_ws,
    output logic        i2s_sd,
    output logic        frame_o
);

    s20_t        ch0_r;
    s20_t        ch1_r;
    s20_t        pair_l_r;
    s20_t        left_s;
    s20_t        right_s;
    logic [63:0] frame_word_s;

    // ch1_r and pair_l_r update together, so {pair_l_r, ch1_r} is always a matched pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0_r    <= 20'sd0;
            ch1_r    <= 20'sd0;
            pair_l_r <= 20'sd0;
        end else if (cycle == AUDIO_CYCLE_0) begin
            ch0_r    <= audio_i;
        end else if (cycle == AUDIO_CYCLE_1) begin
            ch1_r    <= audio_i;
            pair_l_r <= ch0_r;
        end else begin
            ch0_r    <= ch0_r;
        end
    end

    // Slot samples for the next frame, optionally mixed down to mono.
    always_comb begin
        left_s  = pair_l_r;
        right_s = ch1_r;
        if (MONO != 0) begin
            left_s  = mono_mix(pair_l_r, ch1_r);
            right_s = mono_mix(pair_l_r, ch1_r);
        end else begin
            left_s  = pair_l_r;
            right_s = ch1_r;
        end
        frame_word_s = {slot_word(left_s), slot_word(right_s)};
    end

    sid_i2s_tx #(
        .SCK_DIV (SCK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_word (frame_word_s),
        .i2s_sck    (i2s_sck),
        .i2s_ws     (i2s_ws),
        .i2s_sd     (i2s_sd),
        .frame_o    (frame_o)
    );

endmodule
